// File: rtl/rca_pipe_stage.sv
// ----------------------------------------------------------------------------
// rca_pipe_stage
//
// Purpose:
//   Two-stage registered wrapper around an external combinational
//   ripple-carry adder. Stage 1 (operand register) feeds the adder inputs.
//   Stage 2 (result register) captures the adder's sum and carry-out and
//   presents them downstream. Both sides use valid/ready handshakes. Full
//   throughput is one transaction per cycle. Back-pressure propagates
//   combinationally from i_out_ready to o_in_ready.
//
// Optional feature:
//   RCA_PIPE_OVF_EN - when defined, adds o_out_ovf. This is the signed
//   two's-complement overflow flag, registered alongside the result.
//
// Ports:
//   i_clk          clock, all state updates on rising edge
//   i_rst_n        synchronous active-low reset
//   i_in_valid     operand transaction valid
//   o_in_ready     stage can accept operands this cycle
//   i_in_a/i_in_b  operands A and B (N bits)
//   i_in_ci        carry-in
//   o_rca_a/b/ci   adder inputs, straight from the operand register
//   i_rca_s        adder sum (combinational from o_rca_*)
//   i_rca_co       adder carry-out
//   o_out_valid    result valid
//   i_out_ready    downstream accepts result
//   o_out_s        registered sum
//   o_out_co       registered carry-out
//   o_out_cnt      completed output handshakes, wraps at 16 bits
//   o_out_ovf      registered signed overflow (RCA_PIPE_OVF_EN only)
// ----------------------------------------------------------------------------
module rca_pipe_stage #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_a,
    input  logic [N-1:0] i_in_b,
    input  logic         i_in_ci,
    output logic [N-1:0] o_rca_a,
    output logic [N-1:0] o_rca_b,
    output logic         o_rca_ci,
    input  logic [N-1:0] i_rca_s,
    input  logic         i_rca_co,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out_s,
    output logic         o_out_co,
    output logic [15:0]  o_out_cnt
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic         o_out_ovf
`endif
);

    // Stage 1: operand register
    logic         r_v1;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic         r_op_ci;

    // Stage 2: result register
    logic         r_v2;
    logic [N-1:0] r_res_s;
    logic         r_res_co;
`ifdef RCA_PIPE_OVF_EN
    logic         r_res_ovf;
`endif

    logic [15:0]  r_out_cnt;

    logic w_s2_free;
    logic w_adv;
    logic w_in_fire;
    logic w_out_fire;

    // Stage 2 can take new data if it is empty or draining this cycle.
    // Stage 1 can take new data if it is empty or moving forward this cycle.
    assign w_s2_free  = !r_v2 || i_out_ready;
    assign w_adv      = r_v1 && w_s2_free;
    assign o_in_ready = !r_v1 || w_adv;
    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_out_fire = r_v2 && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv) begin
                r_v2 <= 1'b1;
            end else if (w_out_fire) begin
                r_v2 <= 1'b0;
            end

            if (w_in_fire) begin
                r_v1 <= 1'b1;
            end else if (w_adv) begin
                r_v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_ci <= 1'b0;
        end else if (w_in_fire) begin
            r_op_a  <= i_in_a;
            r_op_b  <= i_in_b;
            r_op_ci <= i_in_ci;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_res_s  <= '0;
            r_res_co <= 1'b0;
`ifdef RCA_PIPE_OVF_EN
            r_res_ovf <= 1'b0;
`endif
        end else if (w_adv) begin
            r_res_s  <= i_rca_s;
            r_res_co <= i_rca_co;
`ifdef RCA_PIPE_OVF_EN
            // Like-signed operands producing an opposite-signed sum.
            r_res_ovf <= (r_op_a[N-1] == r_op_b[N-1]) && (i_rca_s[N-1] != r_op_a[N-1]);
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_cnt <= '0;
        end else if (w_out_fire) begin
            r_out_cnt <= r_out_cnt + 16'd1;
        end
    end

    assign o_rca_a     = r_op_a;
    assign o_rca_b     = r_op_b;
    assign o_rca_ci    = r_op_ci;
    assign o_out_valid = r_v2;
    assign o_out_s     = r_res_s;
    assign o_out_co    = r_res_co;
    assign o_out_cnt   = r_out_cnt;
`ifdef RCA_PIPE_OVF_EN
    assign o_out_ovf   = r_res_ovf;
`endif

endmodule

// File: tb/tb_rca_pipe_stage.sv
// ----------------------------------------------------------------------------
// tb_rca_pipe_stage
//
// Purpose:
//   Self-checking bench for rca_pipe_stage. The bench provides a behavioural
//   adder on the rca_* side. An expected result is queued for every accepted
//   input. A negedge monitor pops and compares on every output handshake, and
//   also tracks the handshake count and result stability under stall.
//   Define RCA_PIPE_OVF_EN to also exercise the overflow flag.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_rca_pipe_stage;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_ci;
    logic [N-1:0] rca_a;
    logic [N-1:0] rca_b;
    logic         rca_ci;
    logic [N-1:0] rca_s;
    logic         rca_co;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_s;
    logic         out_co;
    logic [15:0]  out_cnt;
`ifdef RCA_PIPE_OVF_EN
    logic         out_ovf;
`endif

    always #5 clk = ~clk;

    // External combinational adder
    assign {rca_co, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {{N{1'b0}}, rca_ci};

    rca_pipe_stage #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_ci     (in_ci),
        .o_rca_a     (rca_a),
        .o_rca_b     (rca_b),
        .o_rca_ci    (rca_ci),
        .i_rca_s     (rca_s),
        .i_rca_co    (rca_co),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_s     (out_s),
        .o_out_co    (out_co),
        .o_out_cnt   (out_cnt)
`ifdef RCA_PIPE_OVF_EN
        ,
        .o_out_ovf   (out_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Expected result packed as {ovf, co, s}
    logic [N+1:0] exp_q[$];
    logic [15:0]  m_cnt = '0;
    logic         stall_prev = 1'b0;
    logic [N+1:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: arithmetic sum plus signed-range overflow test
    function automatic logic [N+1:0] model(input int a, input int b, input int ci);
        int usum;
        int sa;
        int sb;
        int ssum;
        logic ovf;
        logic co;
        logic [N-1:0] s;
        usum = a + b + ci;
        s    = N'(usum % (1 << N));
        co   = (usum >= (1 << N));
        sa   = (a >= (1 << (N-1))) ? a - (1 << N) : a;
        sb   = (b >= (1 << (N-1))) ? b - (1 << N) : b;
        ssum = sa + sb + ci;
        ovf  = (ssum > (1 << (N-1)) - 1) || (ssum < -(1 << (N-1)));
        return {ovf, co, s};
    endfunction

    function automatic logic [N+1:0] cur_out();
        logic [N+1:0] r;
        r = {1'b0, out_co, out_s};
`ifdef RCA_PIPE_OVF_EN
        r[N+1] = out_ovf;
`endif
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        logic [N+1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt      = '0;
            stall_prev = 1'b0;
        end else begin
            chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
            if (stall_prev) begin
                chk("stall_stable", 32'(cur_out()), 32'(held));
                chk("stall_valid", 32'(out_valid), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_s", 32'(out_s), 32'(e[N-1:0]));
                    chk("out_co", 32'(out_co), 32'(e[N]));
`ifdef RCA_PIPE_OVF_EN
                    chk("out_ovf", 32'(out_ovf), 32'(e[N+1]));
`endif
                end
                m_cnt = m_cnt + 16'd1;
            end
            stall_prev = out_valid && !out_ready;
            held       = cur_out();
            if (in_valid && in_ready)
                exp_q.push_back(model(int'(in_a), int'(in_b), int'(in_ci)));
        end
    end

    task automatic send(input int a, input int b, input int ci);
        int  t;
        logic acc;
        in_valid = 1'b1;
        in_a     = N'(a);
        in_b     = N'(b);
        in_ci    = ci[0];
        t = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 500);
        if (!acc) chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_rca_a", 32'(rca_a), 32'd0);

        // Single op 7+9+0 -> s=0, co=1, valid for exactly one cycle
        send(7, 9, 0);
        chk("single_early_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_s", 32'(out_s), 32'd0);
        chk("single_co", 32'(out_co), 32'd1);
        @(posedge clk); #1;
        chk("single_valid_drop", 32'(out_valid), 32'd0);
        chk("single_cnt", 32'(out_cnt), 32'd1);

        // Back-to-back stream
        send(15, 15, 1);
        chk("b2b_ready0", 32'(in_ready), 32'd1);
        send(3, 4, 0);
        chk("b2b_ready1", 32'(in_ready), 32'd1);
        chk("b2b_out0_s", 32'(out_s), 32'd15);
        chk("b2b_out0_co", 32'(out_co), 32'd1);
        send(0, 0, 1);
        chk("b2b_ready2", 32'(in_ready), 32'd1);
        chk("b2b_out1_s", 32'(out_s), 32'd7);
        chk("b2b_out1_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("b2b_out2_s", 32'(out_s), 32'd1);
        chk("b2b_out2_co", 32'(out_co), 32'd0);
        chk("b2b_out2_valid", 32'(out_valid), 32'd1);
        drain();

        // Stall with both stages full
        base = int'(m_cnt);
        out_ready = 1'b0;
        send(1, 2, 0);
        send(5, 6, 1);
        in_valid = 1'b1;
        in_a = 4'd9; in_b = 4'd9; in_ci = 1'b0;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_s", 32'(out_s), 32'd3);
        repeat (3) begin @(posedge clk); #1; end
        chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
        chk("stall_out_s_hold", 32'(out_s), 32'd3);
        chk("stall_op_q", 32'(rca_a), 32'd5);
        out_ready = 1'b1;
        send(9, 9, 0);
        drain();
        chk("stall_cnt", 32'(out_cnt), 32'(base + 3));

        // Reset with both stages full
        out_ready = 1'b0;
        send(1, 1, 0);
        send(2, 3, 0);
        in_valid = 1'b1;
        in_a = 4'd4; in_b = 4'd4; in_ci = 1'b0;
        do_reset();
        in_valid = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst2_rca_a", 32'(rca_a), 32'd0);
        chk("rst2_rca_b", 32'(rca_b), 32'd0);
        out_ready = 1'b1;
        send(2, 2, 0);
        @(posedge clk); #1;
        chk("rst2_new_valid", 32'(out_valid), 32'd1);
        chk("rst2_new_s", 32'(out_s), 32'd4);
        chk("rst2_new_co", 32'(out_co), 32'd0);
        drain();

`ifdef RCA_PIPE_OVF_EN
        send(7, 1, 0);
        @(posedge clk); #1;
        chk("ovf_a_s", 32'(out_s), 32'd8);
        chk("ovf_a_ovf", 32'(out_ovf), 32'd1);
        send(8, 8, 0);
        @(posedge clk); #1;
        chk("ovf_b_s", 32'(out_s), 32'd0);
        chk("ovf_b_co", 32'(out_co), 32'd1);
        chk("ovf_b_ovf", 32'(out_ovf), 32'd1);
        send(3, 4, 0);
        @(posedge clk); #1;
        chk("ovf_c_ovf", 32'(out_ovf), 32'd0);
        drain();
`endif

        // Randomized traffic with random back-pressure
        in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_a     = N'($urandom_range(0, 15));
                in_b     = N'($urandom_range(0, 15));
                in_ci    = $urandom_range(0, 1) == 1;
            end
        end
        drain();

        // Counter wrap: 65535 handshakes from reset, then one more
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_valid = 1'b1;
            in_a     = N'($urandom_range(0, 15));
            in_b     = N'($urandom_range(0, 15));
            in_ci    = $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
        end
        drain();
        chk("wrap_pre", 32'(out_cnt), 32'h0000ffff);
        send(6, 5, 1);
        drain();
        chk("wrap_post", 32'(out_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
